// File: rtl/switch_debouncer.sv
// Whole-vector slide-switch debouncer: two-flop synchronizer followed by a
// STABLE/SETTLING FSM that accepts a vector only after it has held long enough.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SW_WIDTH        = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [SW_WIDTH-1:0] sw,
  output logic                sw_valid,
  output logic                sw_changed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE, SETTLING} state_t;

  state_t              r_state;
  logic [SW_WIDTH-1:0] r_sync1;
  logic [SW_WIDTH-1:0] r_sync2;
  logic [SW_WIDTH-1:0] r_candidate;
  logic [SW_WIDTH-1:0] r_sw;
  logic [CNT_W-1:0]    r_count;
  logic                r_sw_valid;
  logic                r_sw_changed;

  logic                w_differs;
  logic                w_one_hot;

  assign w_differs = (r_sync2 != r_candidate);
  assign w_one_hot = ($countones(r_candidate) == 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any movement of the synchronized vector restarts settling for every bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= STABLE;
      r_candidate  <= '0;
      r_count      <= '0;
      r_sw         <= '0;
      r_sw_valid   <= 1'b0;
      r_sw_changed <= 1'b0;
    end else begin
      r_sw_changed <= 1'b0;
      case (r_state)
        STABLE: begin
          if (w_differs) begin
            r_candidate <= r_sync2;
            r_count     <= '0;
            r_state     <= SETTLING;
          end
        end
        SETTLING: begin
          if (w_differs) begin
            r_candidate <= r_sync2;
            r_count     <= '0;
          end else if (r_count == CNT_LAST) begin
            r_state <= STABLE;
            // A bounce that settles back on the current value is silently dropped.
            if (r_candidate != r_sw) begin
              r_sw         <= r_candidate;
              r_sw_valid   <= w_one_hot;
              r_sw_changed <= 1'b1;
            end
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign sw         = r_sw;
  assign sw_valid   = r_sw_valid;
  assign sw_changed = r_sw_changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer: directed scenarios plus random switch activity,
// compared every cycle against a run-length model of the synchronized input.
module tb_switch_debouncer;

  localparam int D = 4;
  localparam int W = 5;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw;
  logic         sw_valid;
  logic         sw_changed;

  int checks;
  int failures;

  // Reference model: the accepted value changes when the synchronized stream
  // (raw delayed by two samples) has held one value for exactly D+1 edges.
  logic [W-1:0] mHist0;
  logic [W-1:0] mHist1;
  logic [W-1:0] mRunVal;
  int           mRunLen;
  logic [W-1:0] mSw;
  logic         mValid;
  logic         mChanged;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .SW_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw(sw),
    .sw_valid(sw_valid),
    .sw_changed(sw_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mHist0   = '0;
    mHist1   = '0;
    mRunVal  = '0;
    mRunLen  = D + 2;
    mSw      = '0;
    mValid   = 1'b0;
    mChanged = 1'b0;
  endtask

  task automatic modelStep(input logic [W-1:0] raw);
    logic [W-1:0] seen;
    seen   = mHist1;
    mHist1 = mHist0;
    mHist0 = raw;
    if (seen == mRunVal) begin
      if (mRunLen < D + 2) mRunLen++;
    end else begin
      mRunVal = seen;
      mRunLen = 1;
    end
    mChanged = 1'b0;
    if (mRunLen == D + 1 && mRunVal != mSw) begin
      mSw      = mRunVal;
      mChanged = 1'b1;
    end
    mValid = ($countones(mSw) == 1);
  endtask

  // Called at a falling edge; drives raw, advances one rising edge, checks, returns at the next falling edge.
  task automatic applyStimulus(input logic [W-1:0] raw);
    sw_raw = raw;
    @(posedge clk);
    modelStep(raw);
    #1;
    checkOutput("sw", 32'(sw), 32'(mSw));
    checkOutput("sw_valid", 32'(sw_valid), 32'(mValid));
    checkOutput("sw_changed", 32'(sw_changed), 32'(mChanged));
    @(negedge clk);
  endtask

  task automatic runHold(input logic [W-1:0] raw, input int n, output int firstEdge, output int pulses);
    firstEdge = -1;
    pulses    = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(raw);
      if (sw_changed) begin
        pulses++;
        if (firstEdge < 0) firstEdge = i;
      end
    end
  endtask

  initial begin
    int firstEdge;
    int pulses;
    int bouncePulses;
    logic [W-1:0] raw;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    sw_raw   = '0;
    modelReset();

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_sw", 32'(sw), 32'h0);
    checkOutput("reset_valid", 32'(sw_valid), 32'h0);
    checkOutput("reset_changed", 32'(sw_changed), 32'h0);
    rst = 1'b0;
    runHold(5'b00000, 5, firstEdge, pulses);
    checkOutput("post_reset_pulses", 32'(pulses), 32'd0);

    $display("[TB] short 01000 glitch");
    runHold(5'b01000, 3, firstEdge, pulses);
    bouncePulses = pulses;
    runHold(5'b00000, 10, firstEdge, pulses);
    checkOutput("glitch_pulses", 32'(bouncePulses + pulses), 32'd0);
    checkOutput("glitch_sw", 32'(sw), 32'h0);

    $display("[TB] 00100 held");
    runHold(5'b00100, 10, firstEdge, pulses);
    checkOutput("hold_edge", 32'(firstEdge), 32'd6);
    checkOutput("hold_pulses", 32'(pulses), 32'd1);
    checkOutput("hold_sw", 32'(sw), 32'h04);
    checkOutput("hold_valid", 32'(sw_valid), 32'h1);

    $display("[TB] bounce then hold 00001");
    runHold(5'b00000, 10, firstEdge, pulses);
    bouncePulses = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(((i / 2) % 2 == 0) ? 5'b00001 : 5'b00000);
      if (sw_changed) bouncePulses++;
    end
    checkOutput("bounce_pulses", 32'(bouncePulses), 32'd0);
    runHold(5'b00001, 10, firstEdge, pulses);
    checkOutput("bounce_edge", 32'(firstEdge), 32'd6);
    checkOutput("bounce_hold_pulses", 32'(pulses), 32'd1);
    checkOutput("bounce_sw", 32'(sw), 32'h01);

    $display("[TB] two bits set");
    runHold(5'b00011, 10, firstEdge, pulses);
    checkOutput("two_edge", 32'(firstEdge), 32'd6);
    checkOutput("two_sw", 32'(sw), 32'h03);
    checkOutput("two_valid", 32'(sw_valid), 32'h0);

    $display("[TB] toggling a different bit every clock");
    raw = 5'b00011;
    bouncePulses = 0;
    for (int i = 0; i < 50; i++) begin
      raw = raw ^ (5'b00001 << (i % W));
      applyStimulus(raw);
      if (sw_changed) bouncePulses++;
    end
    checkOutput("toggle_pulses", 32'(bouncePulses), 32'd0);
    checkOutput("toggle_sw", 32'(sw), 32'h03);

    $display("[TB] reset during settling");
    runHold(5'b00000, 12, firstEdge, pulses);
    runHold(5'b10000, 5, firstEdge, pulses);
    checkOutput("pre_reset_pulses", 32'(pulses), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("async_sw", 32'(sw), 32'h0);
    checkOutput("async_valid", 32'(sw_valid), 32'h0);
    checkOutput("async_changed", 32'(sw_changed), 32'h0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    runHold(5'b10000, 10, firstEdge, pulses);
    checkOutput("rerun_edge", 32'(firstEdge), 32'd6);
    checkOutput("rerun_pulses", 32'(pulses), 32'd1);
    checkOutput("rerun_sw", 32'(sw), 32'h10);

    $display("[TB] random activity");
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 2) == 0) raw = 5'b00001 << $urandom_range(0, W - 1);
      else raw = W'($urandom_range(0, 31));
      runHold(raw, $urandom_range(1, 2 * D + 2), firstEdge, pulses);
    end
    runHold(raw, D + 4, firstEdge, pulses);
    checkOutput("final_sw", 32'(sw), 32'(raw));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
